// File: rtl/axi_output_arbiter.sv
// Per-output-port round-robin arbiter for the cross router. Grants one
// requesting input, holds the grant for the whole packet (through the last
// beat) and muxes that input's beat stream onto the output combinationally.

module axi_output_arbiter #(
  parameter int unsigned CHANNEL_NUMBER = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CHANNEL_WIDTH  = $clog2(CHANNEL_NUMBER)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [CHANNEL_NUMBER-1:0]            req_i,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_data_i,
  input  logic [CHANNEL_NUMBER-1:0]            in_last_i,
  output logic [CHANNEL_NUMBER-1:0]            in_ready_o,
  output logic                                 out_valid_o,
  output logic [DATA_WIDTH-1:0]                out_data_o,
  output logic                                 out_last_o,
  input  logic                                 out_ready_i,
  output logic [CHANNEL_NUMBER-1:0]            grant_o,
  output logic                                 busy_o
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                    state_q, state_d;
  logic [CHANNEL_NUMBER-1:0] grant_q, grant_d;
  logic [CHANNEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic [CHANNEL_NUMBER-1:0] pick;
  logic [CHANNEL_WIDTH-1:0]  g_idx;
  logic                      release_hs;

  // Round-robin search starting at rr_ptr_q, wrapping at CHANNEL_NUMBER
  // (not at the pointer's power-of-two range).
  always_comb begin
    int unsigned idx;
    logic        found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= CHANNEL_NUMBER) begin
        idx = idx - CHANNEL_NUMBER;
      end
      if (!found && req_i[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Encode the one-hot grant into an index for the pointer update.
  always_comb begin
    g_idx = '0;
    for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
      if (grant_q[k]) begin
        g_idx = CHANNEL_WIDTH'(k);
      end
    end
  end

  // Output mux: grant_q is zero while idle, so the bus reads zero unless the
  // granted channel is actually presenting a beat.
  always_comb begin
    out_data_o = '0;
    out_last_o = 1'b0;
    for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
      if (grant_q[k] && req_i[k]) begin
        out_data_o = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        out_last_o = in_last_i[k];
      end
    end
  end

  assign out_valid_o = |(grant_q & req_i);
  assign in_ready_o  = grant_q & {CHANNEL_NUMBER{out_ready_i}};
  assign release_hs  = (state_q == StLocked) && out_ready_i && |(grant_q & req_i & in_last_i);

  // Next-state: lock on arbitration, release only on the last handshake.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StLocked;
          grant_d = pick;
        end
      end
      StLocked: begin
        if (release_hs) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = (g_idx == CHANNEL_WIDTH'(CHANNEL_NUMBER - 1)) ? '0 : g_idx + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == StLocked);

endmodule

// File: tb/tb_axi_output_arbiter.sv
// Directed bench for axi_output_arbiter: reset, packet lock, round-robin
// order, wrap-around, backpressure and reset in the middle of a packet.

module tb_axi_output_arbiter;

  localparam int N = 5;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;

  int checks = 0;
  int errors = 0;

  logic        log_en = 1'b0;
  logic [31:0] xfer_q[$];

  axi_output_arbiter #(
    .CHANNEL_NUMBER(N),
    .DATA_WIDTH    (W)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_ready_i(out_ready),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] d, input logic l);
    in_data[k*W +: W] = d;
    in_last[k]        = l;
  endtask

  // Issue one single-beat packet per requesting channel (data = index) from an
  // IDLE cycle; expect exp_ch granted, then one idle bubble.
  task automatic single_pkt(input logic [N-1:0] r, input int exp_ch);
    logic [N-1:0] exp_g;
    exp_g = '0;
    exp_g[exp_ch] = 1'b1;
    req = r;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) set_ch(k, 32'(k), 1'b1);
    tick(); settle();
    chk("rr_grant", 64'(grant), 64'(exp_g));
    chk("rr_data", 64'(out_data), 64'(exp_ch));
    chk("rr_last", 64'(out_last), 64'd1);
    chk("rr_ready", 64'(in_ready), 64'(exp_g));
    tick(); settle();
    chk("rr_bubble_busy", 64'(busy), 64'd0);
    chk("rr_bubble_valid", 64'(out_valid), 64'd0);
    chk("rr_bubble_grant", 64'(grant), 64'd0);
  endtask

  // Structural invariants, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ($onehot0(grant)) else begin
        errors++;
        $error("FAIL inv_onehot observed=%0b expected=onehot0", grant);
      end
      checks++;
      assert ((in_ready & ~grant) == '0) else begin
        errors++;
        $error("FAIL inv_ready_subset observed=%0b expected_within=%0b", in_ready, grant);
      end
      if (busy) begin
        checks++;
        assert ((out_valid & out_ready) == |(in_ready & req)) else begin
          errors++;
          $error("FAIL inv_handshake observed=%0b expected=%0b", out_valid & out_ready,
                 |(in_ready & req));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (log_en && out_valid && out_ready) xfer_q.push_back(out_data);
  end

  initial begin
    rst_n = 1'b0;
    req = 5'b00100;
    in_data = '0;
    in_last = '0;
    out_ready = 1'b1;
    set_ch(2, 32'hA0, 1'b0);

    // Reset held 3 cycles with a request pending: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    rst_n = 1'b1;

    // 4-beat packet on channel 2.
    for (int b = 0; b < 4; b++) begin
      tick();
      set_ch(2, 32'hA0 + 32'(b), (b == 3));
      settle();
      chk("pkt_grant", 64'(grant), 64'b00100);
      chk("pkt_valid", 64'(out_valid), 64'd1);
      chk("pkt_data", 64'(out_data), 64'hA0 + 64'(b));
      chk("pkt_last", 64'(out_last), 64'(b == 3));
      chk("pkt_ready", 64'(in_ready), 64'b00100);
      chk("pkt_busy", 64'(busy), 64'd1);
    end
    tick();
    req = '0;
    settle();
    chk("pkt_release_busy", 64'(busy), 64'd0);
    chk("pkt_release_grant", 64'(grant), 64'd0);
    chk("pkt_release_data", 64'(out_data), 64'd0);

    // Pointer is 3 after the channel-2 packet; then 4, so wrap picks channel 0.
    single_pkt(5'b01011, 3);
    single_pkt(5'b00011, 0);
    req = '0;

    // Reset during beat 2 of a 4-beat channel-2 packet (pointer is 1 here).
    req = 5'b00100;
    set_ch(2, 32'hB0, 1'b0);
    tick(); settle();
    chk("mid_grant", 64'(grant), 64'b00100);
    chk("mid_data0", 64'(out_data), 64'hB0);
    set_ch(2, 32'hB1, 1'b0);
    rst_n = 1'b0;
    settle();
    chk("mid_data1", 64'(out_data), 64'hB1);
    tick(); settle();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_last", 64'(out_last), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    req = '0;
    // Pointer 0 picks channel 0; a surviving pointer of 1 would pick channel 2.
    single_pkt(5'b00101, 0);

    // All channels requesting: strict rotation from pointer 1.
    single_pkt(5'b11111, 1);
    single_pkt(5'b11111, 2);
    single_pkt(5'b11111, 3);
    single_pkt(5'b11111, 4);
    single_pkt(5'b11111, 0);
    single_pkt(5'b11111, 1);
    req = '0;

    // Lock hold: channel 1 packet (pointer 2), channel 3 joins on beat 2.
    in_last = '0;
    req = 5'b00010;
    set_ch(1, 32'hC0, 1'b0);
    set_ch(3, 32'hD0, 1'b1);
    tick(); settle();
    chk("lock_grant1", 64'(grant), 64'b00010);
    chk("lock_data0", 64'(out_data), 64'hC0);
    tick();
    req = 5'b01010;
    set_ch(1, 32'hC1, 1'b0);
    settle();
    chk("lock_ready_b1", 64'(in_ready), 64'b00010);
    chk("lock_data1", 64'(out_data), 64'hC1);
    tick();
    set_ch(1, 32'hC2, 1'b1);
    settle();
    chk("lock_ready_b2", 64'(in_ready), 64'b00010);
    chk("lock_last", 64'(out_last), 64'd1);
    tick();
    req = 5'b01000;
    settle();
    chk("lock_bubble_grant", 64'(grant), 64'd0);
    chk("lock_bubble_ready", 64'(in_ready), 64'd0);
    tick(); settle();
    chk("lock_grant3", 64'(grant), 64'b01000);
    chk("lock_data3", 64'(out_data), 64'hD0);
    tick();
    req = '0;
    settle();
    chk("lock_done", 64'(busy), 64'd0);

    // Backpressure on a 3-beat channel-2 packet: out_ready 1,0,0,1,1.
    in_last = '0;
    req = 5'b00100;
    set_ch(2, 32'hE0, 1'b0);
    log_en = 1'b1;
    tick();
    out_ready = 1'b1;
    settle();
    chk("bp_c1_ready", 64'(in_ready), 64'b00100);
    chk("bp_c1_data", 64'(out_data), 64'hE0);
    tick();
    out_ready = 1'b0;
    set_ch(2, 32'hE1, 1'b0);
    settle();
    chk("bp_c2_ready", 64'(in_ready), 64'd0);
    chk("bp_c2_data", 64'(out_data), 64'hE1);
    tick(); settle();
    chk("bp_c3_ready", 64'(in_ready), 64'd0);
    chk("bp_c3_data", 64'(out_data), 64'hE1);
    chk("bp_c3_busy", 64'(busy), 64'd1);
    tick();
    out_ready = 1'b1;
    settle();
    chk("bp_c4_ready", 64'(in_ready), 64'b00100);
    chk("bp_c4_data", 64'(out_data), 64'hE1);
    tick();
    set_ch(2, 32'hE2, 1'b1);
    settle();
    chk("bp_c5_ready", 64'(in_ready), 64'b00100);
    chk("bp_c5_last", 64'(out_last), 64'd1);
    tick();
    req = '0;
    settle();
    log_en = 1'b0;
    chk("bp_release", 64'(busy), 64'd0);
    chk("bp_xfer_count", 64'(xfer_q.size()), 64'd3);
    if (xfer_q.size() == 3) begin
      chk("bp_xfer0", 64'(xfer_q[0]), 64'hE0);
      chk("bp_xfer1", 64'(xfer_q[1]), 64'hE1);
      chk("bp_xfer2", 64'(xfer_q[2]), 64'hE2);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
